counter_run_ctrl: RTL

//  Run-control sequencer for the board's tick-driven LED counter. It replaces the free-running
//  MSB-as-clock prescaler with a single-clock tick-enable prescaler. It adds start/stop/clear

---
 rtl/counter_ctrl_pkg.sv | 14 +
 rtl/prescale_tick.sv | 35 +++
 rtl/counter_run_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/counter_ctrl_pkg.sv
// Shared types and defaults for the LED counter run-control block.
package counter_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int unsigned DEFAULT_DIV = 33554432;
  localparam int unsigned DEFAULT_W   = 8;

endpackage

// File: rtl/prescale_tick.sv
// Single-clock tick-enable prescaler: counts 0..DIV-1 while EN, TICK is high on the DIV-1 cycle.
module prescale_tick
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned DIV = DEFAULT_DIV
) (
  input  logic CLK,
  input  logic RST,
  input  logic EN,
  input  logic CLR,
  output logic TICK
);

  localparam int unsigned CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt <= '0;
    end else if (CLR) begin
      r_cnt <= '0;
    end else if (EN) begin
      r_cnt <= w_last ? '0 : r_cnt + CW'(1);
    end
  end

  // A clear in the wrap cycle suppresses that tick.
  assign TICK = EN && !CLR && w_last;

endmodule

// File: rtl/counter_run_ctrl.sv
// Run-control sequencer for the tick-driven LED counter (start/stop/clear, terminal, one-shot).
// Optional down-count mode with DIR port when COUNTER_DIR_EN is defined.
module counter_run_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned DIV         = DEFAULT_DIV,
  parameter int unsigned W           = DEFAULT_W,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         BTN_START,
  input  logic         BTN_STOP,
  input  logic         BTN_CLEAR,
  input  logic [W-1:0] TERMINAL,
  input  logic         ONESHOT,
`ifdef COUNTER_DIR_EN
  input  logic         DIR,
`endif
  output logic [W-1:0] LED,
  output logic         TICK,
  output logic         RUNNING,
  output logic         DONE
);

  logic [2:0] w_btn;
  logic [2:0] w_cmd;

  assign w_btn = {BTN_CLEAR, BTN_STOP, BTN_START};

  for (genvar g = 0; g < 3; g++) begin : g_btn
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        r_sync <= '0;
        r_prev <= 1'b0;
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], w_btn[g]};
        r_prev <= r_sync[SYNC_STAGES-1];
      end
    end

    assign w_cmd[g] = r_sync[SYNC_STAGES-1] & ~r_prev;
  end

  logic w_clear, w_stop, w_start;

  assign w_clear = w_cmd[2];
  assign w_stop  = w_cmd[1] & ~w_cmd[2];
  assign w_start = w_cmd[0] & ~w_cmd[1] & ~w_cmd[2];

  state_t       r_state, w_next;
  logic [W-1:0] r_count, r_term;
  logic         r_oneshot;
  logic         w_hit, w_at_end, w_load, w_pre_en, w_pre_clr;
  logic [W-1:0] w_reload, w_step;
  logic         w_running, w_done;

`ifdef COUNTER_DIR_EN
  logic r_dir;
  assign w_at_end = r_dir ? (r_count == r_term) : (r_count == '0);
  assign w_reload = r_dir ? '0 : r_term;
  assign w_step   = r_dir ? r_count + W'(1) : r_count - W'(1);
`else
  assign w_at_end = (r_count == r_term);
  assign w_reload = '0;
  assign w_step   = r_count + W'(1);
`endif

  assign w_load    = w_start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_pre_en  = (r_state == ST_RUN);
  assign w_pre_clr = w_clear || (r_state == ST_IDLE) || (r_state == ST_DONE);

  prescale_tick #(.DIV(DIV)) u_prescale (
    .CLK  (CLK),
    .RST  (RST),
    .EN   (w_pre_en),
    .CLR  (w_pre_clr),
    .TICK (w_hit)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_clear) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (w_start) w_next = ST_RUN;
        ST_RUN: begin
          if (w_stop)                              w_next = ST_PAUSED;
          else if (w_hit && w_at_end && r_oneshot) w_next = ST_DONE;
        end
        ST_PAUSED: if (w_start) w_next = ST_RUN;
        ST_DONE:   if (w_start) w_next = ST_RUN;
        default:   w_next = ST_IDLE;
      endcase
    end
  end

  // Terminal, mode and direction are captured only on a fresh start, never on resume.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_count   <= '0;
      r_term    <= '0;
      r_oneshot <= 1'b0;
`ifdef COUNTER_DIR_EN
      r_dir     <= 1'b1;
`endif
    end else if (w_clear) begin
      r_count <= '0;
    end else if (w_load) begin
      r_term    <= TERMINAL;
      r_oneshot <= ONESHOT;
`ifdef COUNTER_DIR_EN
      r_dir     <= DIR;
      r_count   <= DIR ? '0 : TERMINAL;
`else
      r_count   <= '0;
`endif
    end else if (w_hit) begin
      if (!w_at_end)       r_count <= w_step;
      else if (!r_oneshot) r_count <= w_reload;
    end
  end

  always_comb begin
    w_running = (r_state == ST_RUN);
    w_done    = (r_state == ST_DONE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      LED     <= '0;
      TICK    <= 1'b0;
      RUNNING <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      LED     <= r_count;
      TICK    <= w_hit;
      RUNNING <= w_running;
      DONE    <= w_done;
    end
  end

endmodule
